// File: rtl/cpu_memory.sv
`default_nettype none
// ============================================================================
// Module   : cpu_memory
// Brief    : Memory-access pipeline stage. Accepts toggle-strobed records from
//            execute, performs at most one load/store on a single-outstanding
//            request/ready bus and emits a toggle-strobed writeback record.
// Revision : 1.0 - initial release
// ============================================================================
module cpu_memory (
    input  logic          i_clock,
    input  logic          i_reset,
    input  logic [107:0]  i_data,
    output logic          o_busy,
    output logic [38:0]   o_data,
    output logic          o_fault,
    output logic          o_bus_request,
    output logic          o_bus_rw,
    output logic [31:0]   o_bus_address,
    output logic [3:0]    o_bus_wmask,
    output logic [31:0]   o_bus_wdata,
    input  logic          i_bus_ready,
    input  logic [31:0]   i_bus_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2
    } state_t;

    state_t       state_q, state_d;
    logic         last_strobe_q, last_strobe_d;
    logic         pend_q, pend_d;       // a latched record waits to be processed
    logic         bad_q, bad_d;         // latched record failed the fault check
    logic [5:0]   rd_q, rd_d;
    logic [31:0]  value_q, value_d;
    logic [31:0]  addr_q, addr_d;
    logic [1:0]   width_q, width_d;
    logic         signed_q, signed_d;
    logic         mrd_q, mrd_d;
    logic         mwr_q, mwr_d;
    logic [31:0]  sdata_q, sdata_d;
    logic [38:0]  data_q, data_d;
    logic         fault_q, fault_d;
    logic         req_q, req_d;
    logic         rw_q, rw_d;
    logic [31:0]  baddr_q, baddr_d;
    logic [3:0]   wmask_q, wmask_d;
    logic [31:0]  wdata_q, wdata_d;

    // Incoming record fields
    logic [31:0]  w_in_addr;
    logic [1:0]   w_in_width;
    logic         w_in_mrd, w_in_mwr;
    logic         w_in_fault;
    logic         w_hold;
    logic         w_accept;
    logic [7:0]   w_byte;
    logic [15:0]  w_half;
    logic [31:0]  w_load;
    logic [3:0]   w_wmask;
    logic [31:0]  w_wdata;

    assign w_in_addr  = i_data[68:37];
    assign w_in_width = i_data[36:35];
    assign w_in_mrd   = i_data[33];
    assign w_in_mwr   = i_data[32];

    assign w_in_fault = (w_in_width == 2'd3)
                      || ((w_in_width == 2'd1) && w_in_addr[0])
                      || ((w_in_width == 2'd2) && (w_in_addr[1:0] != 2'b00))
                      || (w_in_mrd && w_in_mwr);

    // A latched memory op must start its access before another record may
    // overwrite the latches; pass-through records drain while the next is taken.
    assign w_hold   = pend_q && !bad_q && (mrd_q || mwr_q);
    assign w_accept = (state_q == ST_IDLE) && (i_data[107] != last_strobe_q) && !w_hold;

    // Load lane selection and extension
    always_comb begin
        w_byte = i_bus_rdata[7:0];
        case (addr_q[1:0])
            2'd0: w_byte = i_bus_rdata[7:0];
            2'd1: w_byte = i_bus_rdata[15:8];
            2'd2: w_byte = i_bus_rdata[23:16];
            default: w_byte = i_bus_rdata[31:24];
        endcase
        w_half = addr_q[1] ? i_bus_rdata[31:16] : i_bus_rdata[15:0];
        case (width_q)
            2'd0:    w_load = {{24{signed_q & w_byte[7]}}, w_byte};
            2'd1:    w_load = {{16{signed_q & w_half[15]}}, w_half};
            default: w_load = i_bus_rdata;
        endcase
    end

    // Store byte enables and lane replication
    always_comb begin
        case (width_q)
            2'd0: begin
                w_wmask = 4'b0001 << addr_q[1:0];
                w_wdata = {4{sdata_q[7:0]}};
            end
            2'd1: begin
                w_wmask = 4'b0011 << addr_q[1:0];
                w_wdata = {2{sdata_q[15:0]}};
            end
            default: begin
                w_wmask = 4'hF;
                w_wdata = sdata_q;
            end
        endcase
    end

    // Next-state logic: acceptance, fault/pass-through emit and bus sequencing
    always_comb begin
        state_d       = state_q;
        last_strobe_d = last_strobe_q;
        pend_d        = w_accept;
        bad_d         = bad_q;
        rd_d          = rd_q;
        value_d       = value_q;
        addr_d        = addr_q;
        width_d       = width_q;
        signed_d      = signed_q;
        mrd_d         = mrd_q;
        mwr_d         = mwr_q;
        sdata_d       = sdata_q;
        data_d        = data_q;
        fault_d       = 1'b0;
        req_d         = req_q;
        rw_d          = rw_q;
        baddr_d       = baddr_q;
        wmask_d       = wmask_q;
        wdata_d       = wdata_q;

        if (w_accept) begin
            last_strobe_d = i_data[107];
            rd_d          = i_data[106:101];
            value_d       = i_data[100:69];
            addr_d        = w_in_addr;
            width_d       = w_in_width;
            signed_d      = i_data[34];
            mrd_d         = w_in_mrd;
            mwr_d         = w_in_mwr;
            sdata_d       = i_data[31:0];
            bad_d         = w_in_fault;
        end

        case (state_q)
            ST_IDLE: begin
                if (pend_q) begin
                    if (bad_q) begin
                        data_d  = {~data_q[38], 6'd0, 32'd0};
                        fault_d = 1'b1;
                    end else if (mrd_q) begin
                        state_d = ST_READ;
                        req_d   = 1'b1;
                        rw_d    = 1'b0;
                        baddr_d = {addr_q[31:2], 2'b00};
                        wmask_d = 4'h0;
                        wdata_d = 32'd0;
                    end else if (mwr_q) begin
                        state_d = ST_WRITE;
                        req_d   = 1'b1;
                        rw_d    = 1'b1;
                        baddr_d = {addr_q[31:2], 2'b00};
                        wmask_d = w_wmask;
                        wdata_d = w_wdata;
                    end else begin
                        data_d  = {~data_q[38], rd_q, value_q};
                    end
                end
            end
            ST_READ: begin
                if (i_bus_ready) begin
                    data_d  = {~data_q[38], rd_q, w_load};
                    req_d   = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            ST_WRITE: begin
                if (i_bus_ready) begin
                    data_d  = {~data_q[38], rd_q, value_q};
                    req_d   = 1'b0;
                    rw_d    = 1'b0;
                    wmask_d = 4'h0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q       <= ST_IDLE;
            last_strobe_q <= 1'b0;
            pend_q        <= 1'b0;
            bad_q         <= 1'b0;
            rd_q          <= 6'd0;
            value_q       <= 32'd0;
            addr_q        <= 32'd0;
            width_q       <= 2'd0;
            signed_q      <= 1'b0;
            mrd_q         <= 1'b0;
            mwr_q         <= 1'b0;
            sdata_q       <= 32'd0;
            data_q        <= 39'd0;
            fault_q       <= 1'b0;
            req_q         <= 1'b0;
            rw_q          <= 1'b0;
            baddr_q       <= 32'd0;
            wmask_q       <= 4'h0;
            wdata_q       <= 32'd0;
        end else begin
            state_q       <= state_d;
            last_strobe_q <= last_strobe_d;
            pend_q        <= pend_d;
            bad_q         <= bad_d;
            rd_q          <= rd_d;
            value_q       <= value_d;
            addr_q        <= addr_d;
            width_q       <= width_d;
            signed_q      <= signed_d;
            mrd_q         <= mrd_d;
            mwr_q         <= mwr_d;
            sdata_q       <= sdata_d;
            data_q        <= data_d;
            fault_q       <= fault_d;
            req_q         <= req_d;
            rw_q          <= rw_d;
            baddr_q       <= baddr_d;
            wmask_q       <= wmask_d;
            wdata_q       <= wdata_d;
        end
    end

    assign o_busy        = (state_q != ST_IDLE);
    assign o_data        = data_q;
    assign o_fault       = fault_q;
    assign o_bus_request = req_q;
    assign o_bus_rw      = rw_q;
    assign o_bus_address = baddr_q;
    assign o_bus_wmask   = wmask_q;
    assign o_bus_wdata   = wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_cpu_memory.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpu_memory
// Brief    : Self-checking bench for cpu_memory: vector table of single-cycle
//            records plus directed load/store, busy-toggle and reset sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cpu_memory;

    logic          clk;
    logic          rst;
    logic [107:0]  i_data;
    logic          o_busy;
    logic [38:0]   o_data;
    logic          o_fault;
    logic          o_bus_request;
    logic          o_bus_rw;
    logic [31:0]   o_bus_address;
    logic [3:0]    o_bus_wmask;
    logic [31:0]   o_bus_wdata;
    logic          i_bus_ready;
    logic [31:0]   i_bus_rdata;

    cpu_memory dut (
        .i_clock       (clk),
        .i_reset       (rst),
        .i_data        (i_data),
        .o_busy        (o_busy),
        .o_data        (o_data),
        .o_fault       (o_fault),
        .o_bus_request (o_bus_request),
        .o_bus_rw      (o_bus_rw),
        .o_bus_address (o_bus_address),
        .o_bus_wmask   (o_bus_wmask),
        .o_bus_wdata   (o_bus_wdata),
        .i_bus_ready   (i_bus_ready),
        .i_bus_rdata   (i_bus_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   toggles  = 0;
    logic strobe_in;
    logic exp_strobe;

    always @(o_data[38]) toggles++;

    typedef struct {
        logic [5:0]  rd;
        logic [31:0] val;
        logic [31:0] addr;
        logic [1:0]  width;
        logic        sgn;
        logic        mrd;
        logic        mwr;
        logic [31:0] sdata;
        logic [5:0]  exp_rd;
        logic [31:0] exp_val;
        logic        exp_fault;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send(input logic [5:0] rd, input logic [31:0] val, input logic [31:0] addr,
                        input logic [1:0] width, input logic sgn, input logic mrd,
                        input logic mwr, input logic [31:0] sdata);
        strobe_in = ~strobe_in;
        i_data = {strobe_in, rd, val, addr, width, sgn, mrd, mwr, sdata};
    endtask

    // One memory op: request appears two edges after presentation, ready is
    // raised in request cycle n_wait, record emitted on that edge.
    task automatic run_mem(input logic [5:0] rd, input logic [31:0] val, input logic [31:0] addr,
                           input logic [1:0] width, input logic sgn, input logic mrd,
                           input logic mwr, input logic [31:0] sdata, input int n_wait,
                           input logic [31:0] rdata, input logic [31:0] exp_addr,
                           input logic [3:0] exp_wmask, input logic [31:0] exp_wdata,
                           input logic [31:0] exp_val, input string tag, input bit inject);
        send(rd, val, addr, width, sgn, mrd, mwr, sdata);
        @(negedge clk);
        chk({tag, "_req_early"}, o_bus_request, 1'b0);
        chk({tag, "_busy_early"}, o_busy, 1'b0);
        for (int k = 0; k < n_wait; k++) begin
            @(negedge clk);
            chk({tag, "_req"}, o_bus_request, 1'b1);
            chk({tag, "_rw"}, o_bus_rw, mwr);
            chk({tag, "_addr"}, o_bus_address, exp_addr);
            chk({tag, "_wmask"}, o_bus_wmask, exp_wmask);
            if (mwr) chk({tag, "_wdata"}, o_bus_wdata, exp_wdata);
            chk({tag, "_busy"}, o_busy, 1'b1);
            chk({tag, "_strobe_held"}, o_data[38], exp_strobe);
            if (inject && k == 0) send(6'd9, 32'h0000_0099, 32'd0, 2'd0, 1'b0, 1'b0, 1'b0, 32'd0);
            if (k == n_wait - 1) begin
                i_bus_ready = 1'b1;
                i_bus_rdata = rdata;
            end
        end
        @(negedge clk);
        i_bus_ready = 1'b0;
        i_bus_rdata = 32'hDEAD_0000;
        exp_strobe = ~exp_strobe;
        chk({tag, "_odata"}, o_data, {exp_strobe, rd, exp_val});
        chk({tag, "_req_done"}, o_bus_request, 1'b0);
        chk({tag, "_busy_done"}, o_busy, 1'b0);
    endtask

    initial begin
        int tog0;
        rst         = 1'b1;
        i_data      = '0;
        i_bus_ready = 1'b0;
        i_bus_rdata = 32'hDEAD_0000;
        strobe_in   = 1'b0;
        exp_strobe  = 1'b0;

        //           rd     val            addr          w     s     rd    wr    sdata  exp_rd exp_val        fault
        vecs[0] = '{6'd5,  32'h1234_5678, 32'h0000_0000, 2'd0, 1'b0, 1'b0, 1'b0, 32'd0, 6'd5,  32'h1234_5678, 1'b0};
        vecs[1] = '{6'd63, 32'hFFFF_FFFF, 32'h0000_0010, 2'd2, 1'b0, 1'b0, 1'b0, 32'd0, 6'd63, 32'hFFFF_FFFF, 1'b0};
        vecs[2] = '{6'd4,  32'h1111_1111, 32'h0000_0301, 2'd2, 1'b0, 1'b1, 1'b0, 32'd0, 6'd0,  32'h0,          1'b1};
        vecs[3] = '{6'd6,  32'h2222_2222, 32'h0000_0000, 2'd3, 1'b0, 1'b0, 1'b1, 32'd0, 6'd0,  32'h0,          1'b1};
        vecs[4] = '{6'd7,  32'h3333_3333, 32'h0000_0201, 2'd1, 1'b1, 1'b1, 1'b0, 32'd0, 6'd0,  32'h0,          1'b1};
        vecs[5] = '{6'd8,  32'h4444_4444, 32'h0000_0200, 2'd0, 1'b0, 1'b1, 1'b1, 32'd0, 6'd0,  32'h0,          1'b1};
        vecs[6] = '{6'd0,  32'hDEAD_BEEF, 32'h0000_0000, 2'd0, 1'b0, 1'b0, 1'b0, 32'd0, 6'd0,  32'hDEAD_BEEF, 1'b0};

        repeat (3) @(negedge clk);
        chk("rst_odata", o_data, 39'd0);
        chk("rst_busy", o_busy, 1'b0);
        chk("rst_fault", o_fault, 1'b0);
        chk("rst_req", o_bus_request, 1'b0);
        chk("rst_rw", o_bus_rw, 1'b0);
        chk("rst_addr", o_bus_address, 32'd0);
        chk("rst_wmask", o_bus_wmask, 4'd0);
        chk("rst_wdata", o_bus_wdata, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Single-cycle records: pass-through and rejected accesses
        for (int i = 0; i < 7; i++) begin
            send(vecs[i].rd, vecs[i].val, vecs[i].addr, vecs[i].width, vecs[i].sgn,
                 vecs[i].mrd, vecs[i].mwr, vecs[i].sdata);
            @(negedge clk);
            chk("vec_req_early", o_bus_request, 1'b0);
            chk("vec_strobe_early", o_data[38], exp_strobe);
            @(negedge clk);
            exp_strobe = ~exp_strobe;
            chk("vec_odata", o_data, {exp_strobe, vecs[i].exp_rd, vecs[i].exp_val});
            chk("vec_fault", o_fault, vecs[i].exp_fault);
            chk("vec_req", o_bus_request, 1'b0);
            chk("vec_busy", o_busy, 1'b0);
            @(negedge clk);
            chk("vec_fault_pulse_end", o_fault, 1'b0);
        end

        // Back-to-back pass-through records, no bubbles
        send(6'd1, 32'h0000_0011, 32'd0, 2'd0, 1'b0, 1'b0, 1'b0, 32'd0);
        @(negedge clk);
        send(6'd2, 32'h0000_0022, 32'd0, 2'd0, 1'b0, 1'b0, 1'b0, 32'd0);
        @(negedge clk);
        exp_strobe = ~exp_strobe;
        chk("b2b_first", o_data, {exp_strobe, 6'd1, 32'h0000_0011});
        @(negedge clk);
        exp_strobe = ~exp_strobe;
        chk("b2b_second", o_data, {exp_strobe, 6'd2, 32'h0000_0022});

        // Loads and stores
        run_mem(6'd7, 32'd0, 32'h0000_0103, 2'd0, 1'b1, 1'b1, 1'b0, 32'd0, 3,
                32'h80FF_FF00, 32'h0000_0100, 4'h0, 32'd0, 32'hFFFF_FF80, "lb_s", 1'b0);
        run_mem(6'd8, 32'd0, 32'h0000_0103, 2'd0, 1'b0, 1'b1, 1'b0, 32'd0, 3,
                32'h80FF_FF00, 32'h0000_0100, 4'h0, 32'd0, 32'h0000_0080, "lb_u", 1'b0);
        run_mem(6'd10, 32'd0, 32'h0000_0102, 2'd1, 1'b1, 1'b1, 1'b0, 32'd0, 1,
                32'h80FF_FF00, 32'h0000_0100, 4'h0, 32'd0, 32'hFFFF_80FF, "lh_s", 1'b0);
        run_mem(6'd11, 32'h5555_AAAA, 32'h0000_0202, 2'd1, 1'b0, 1'b0, 1'b1, 32'h0000_ABCD, 2,
                32'd0, 32'h0000_0200, 4'b1100, 32'hABCD_ABCD, 32'h5555_AAAA, "sh", 1'b0);
        run_mem(6'd3, 32'hCAFE_0000, 32'h0000_0101, 2'd0, 1'b0, 1'b0, 1'b1, 32'h0000_005A, 2,
                32'd0, 32'h0000_0100, 4'b0010, 32'h5A5A_5A5A, 32'hCAFE_0000, "sb", 1'b0);

        // Toggle presented while busy in a load
        tog0 = toggles;
        run_mem(6'd12, 32'd0, 32'h0000_0040, 2'd2, 1'b0, 1'b1, 1'b0, 32'd0, 3,
                32'h1357_9BDF, 32'h0000_0040, 4'h0, 32'd0, 32'h1357_9BDF, "lw_busy", 1'b1);
        @(negedge clk);
        chk("busy_tog_wait", o_data, {exp_strobe, 6'd12, 32'h1357_9BDF});
        @(negedge clk);
        exp_strobe = ~exp_strobe;
        chk("busy_tog_emit", o_data, {exp_strobe, 6'd9, 32'h0000_0099});
        repeat (2) @(negedge clk);
        chk("busy_tog_count", toggles - tog0, 2);

        // Reset during a read with ready low
        send(6'd13, 32'd0, 32'h0000_0400, 2'd2, 1'b0, 1'b1, 1'b0, 32'd0);
        repeat (2) @(negedge clk);
        chk("rmid_req_before", o_bus_request, 1'b1);
        rst       = 1'b1;
        i_data    = '0;
        strobe_in = 1'b0;
        @(negedge clk);
        chk("rmid_req", o_bus_request, 1'b0);
        chk("rmid_odata", o_data, 39'd0);
        chk("rmid_busy", o_busy, 1'b0);
        rst = 1'b0;
        tog0 = toggles;
        repeat (4) @(negedge clk);
        chk("rmid_no_toggle", toggles - tog0, 0);
        chk("rmid_odata_after", o_data, 39'd0);
        chk("rmid_req_after", o_bus_request, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cpu_memory.md
# cpu_memory

Memory-access stage of the CPU pipeline; the producer side of the toggle-strobe writeback link. It accepts one instruction record at a time from execute, marked by a toggle strobe. It performs at most one load or store over a single-outstanding request/ready data bus. It then emits a 39-bit writeback record, also marked by a toggle strobe, to the writeback stage, which counts each toggle as one retired instruction.

## Interface
Parameters: none.

- i_clock  in  1  clock; all logic on rising edge.
- i_reset  in  1  reset: synchronous, active-high.
- i_data  in  108  record from execute:
  - [107] strobe (toggles once per new record)
  - [106:101] rd
  - [100:69] rd value
  - [68:37] mem address
  - [36:35] width (0 byte, 1 half, 2 word, 3 reserved)
  - [34] signed load
  - [33] mem read
  - [32] mem write
  - [31:0] store data
- o_busy  out  1  high while the stage cannot accept a record (state != IDLE).
- o_data  out  39  writeback record: [38] strobe, [37:32] rd (0 = no register write), [31:0] value.
- o_fault  out  1  one-cycle pulse on a rejected access.
- o_bus_request  out  1  bus access pending.
- o_bus_rw  out  1  1 = write, 0 = read.
- o_bus_address  out  32  word address: mem address with [1:0] forced to 0.
- o_bus_wmask  out  4  byte enables for writes; 0 for reads.
- o_bus_wdata  out  32  store data shifted into its byte lanes.
- i_bus_ready  in  1  access complete; i_bus_rdata is valid in the same cycle.
- i_bus_rdata  in  32  read data.

## Operation
- Registers: last_strobe (strobe of the last accepted record), state (IDLE, READ, WRITE), latched rd/value/address/width/signed.
- Acceptance: in IDLE, a record is new when i_data[107] != last_strobe. On acceptance, last_strobe <= i_data[107] and all fields are latched. A toggle arriving while busy is not lost; it is accepted on the first IDLE cycle.
- Fault check, evaluated at acceptance:
  - width == 3
  - half with address[0] = 1
  - word with address[1:0] != 0
  - read and write both set
  - On fault: no bus access; emit record with rd = 0, value = 0; o_fault pulses; stay IDLE.
- No memory op: emit {rd, rd value} next cycle; stay IDLE.
- Read: go to READ with o_bus_request = 1, o_bus_rw = 0. When i_bus_ready = 1:
  - Select the byte/half from i_bus_rdata by address[1:0]: byte lane = addr[1:0], half lane = addr[1].
  - Sign-extend if signed = 1, else zero-extend.
  - Emit {rd, loaded value}; return to IDLE.
- Write: go to WRITE with o_bus_request = 1, o_bus_rw = 1.
  - byte: wmask = 1 << addr[1:0], wdata = data[7:0] replicated into all four lanes.
  - half: wmask = 3 << addr[1:0], wdata = data[15:0] replicated into both halves.
  - word: wmask = 4'hF, wdata = data.
  - On i_bus_ready: emit {rd, rd value}; return to IDLE.
- Emit: o_data[37:0] <= record and o_data[38] <= ~o_data[38] in the same edge. Exactly one toggle per accepted record, including faults. o_data holds its value between emits.

## Timing
- Reset: o_data = 0, last_strobe = 0, state IDLE, o_busy = 0, o_fault = 0, o_bus_request = 0, o_bus_rw = 0, o_bus_address = 0, o_bus_wmask = 0, o_bus_wdata = 0.
- Reset mid-access: the request drops at the next edge, no record is emitted, and the bus is expected to be reset too.
- Pass-through or fault: toggle sampled at edge T; o_data and strobe update at edge T+1; zero bubbles for back-to-back records.
- Memory op: accepted at edge T.
  - o_bus_request is high from T+1 and is held with stable address/rw/wmask/wdata until i_bus_ready is sampled high at edge R.
  - o_data updates at R; request is low after R.
  - Ready in the first request cycle gives a 2-cycle accept-to-emit latency.
- o_busy is registered: high from T+1 through R.
- i_bus_ready is ignored while o_bus_request = 0.
- Only one outstanding access exists at any time.

## Test plan
- Pass-through: toggle strobe with rd = 5, value 0x1234_5678, no mem. Expect one cycle later o_data = {1, 5, 0x12345678}, no bus request, busy never asserted.
- Signed byte load: addr 0x103, rdata 0x80FF_FF00, ready after 3 cycles. Expect bus_address 0x100 held for 3 cycles, then value 0xFFFF_FF80. Repeat with signed = 0: expect 0x0000_0080.
- Half store: addr 0x202, data 0xABCD. Expect wmask 4'b1100, wdata 0xABCD_ABCD, rw = 1, strobe toggles on the ready cycle.
- Misaligned word at 0x301: expect no request, o_fault pulse, o_data = {toggled, 0, 0}.
- Toggle presented while busy in a load: expect it accepted the cycle after return to IDLE. Expect exactly 2 output toggles in total.
- Reset asserted in READ with ready low: expect request 0 next cycle, o_data = 0, and no toggle after reset releases.
